// File: rtl/dsp_mem_arb_pkg.sv
// dsp_mem_arb_pkg: shared types and helpers for the DSP memory write arbiter.
//   state_t   : arbiter FSM states
//   CMD_SEL_BIT / RSVD_MSB / RSVD_LSB : port address map fields
//   rr_pick() : round-robin index search, up to RR_MAX requesters
package dsp_mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int CMD_SEL_BIT = 12;
  localparam int RSVD_MSB    = 11;
  localparam int RSVD_LSB    = 10;
  localparam int RR_MAX      = 8;

  // First valid index after last_grant, wrapping modulo n. Returns
  // last_grant unchanged when nothing is valid (caller gates with |valid).
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        last_grant,
                                         input int                n);
    logic [2:0] idx;
    logic       found;
    rr_pick = last_grant;
    found   = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (!found && k <= n) begin
        idx = 3'((int'(last_grant) + k) % n);
        if (valid[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dsp_mem_write_arb_rr_select.sv
// rr_select: combinational round-robin priority picker.
//   i_valid : per-requester request
//   i_last  : index granted most recently (lowest priority now)
//   o_sel   : winning index (meaningful only when o_any)
//   o_any   : at least one request present
module rr_select
  import dsp_mem_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_sel,
  output logic             o_any
);

  logic [RR_MAX-1:0] w_valid;
  logic [2:0]        w_pick;

  always_comb begin
    w_valid              = '0;
    w_valid[N_REQ-1:0]   = i_valid;
    w_pick               = rr_pick(w_valid, 3'(i_last), N_REQ);
    o_sel                = IW'(w_pick);
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/dsp_mem_write_arb.sv
// dsp_mem_write_arb: burst-locked round-robin arbiter for the single DSP
// memory write port.
//   clk, reset       : clock, synchronous active-high reset
//   req_valid/ready  : per-source beat handshake (ready only to the owner)
//   req_last         : beat closes the source's burst
//   req_addr/data    : packed per-source address/data, source i at [i*W +: W]
//   mem_write_*      : registered write port to the DSP unit
//   grant            : one-hot current owner, busy : owner active
//   err_reserved     : sticky reserved-address flag
// Optional feature: define DSP_MEM_WRITE_ARB_ADDR_CHECK_EN to drop writes to
// reserved command space (addr[12]==0, addr[11:10]!=0) and flag them.
module dsp_mem_write_arb
  import dsp_mem_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int GAP_MAX    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0]       mem_write_addr,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  output logic                        mem_write_en,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic                        err_reserved
);

  localparam int IW = (N_REQ > 1)     ? $clog2(N_REQ)     : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int GW = (GAP_MAX > 1)   ? $clog2(GAP_MAX)   : 1;

  state_t                r_state;
  logic [N_REQ-1:0]      r_grant;
  logic [IW-1:0]         r_last_grant;
  logic [BW-1:0]         r_beat_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en;

  logic [IW-1:0]         w_sel;
  logic                  w_any;
  logic                  w_hs;
  logic                  w_own_last;
  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic                  w_fwd;
  logic                  w_exit;

  rr_select #(.N_REQ(N_REQ)) u_rr (
    .i_valid (req_valid),
    .i_last  (r_last_grant),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  // While in BURST, r_last_grant is the owner index, so it steers the mux.
  assign w_own_addr = req_addr[int'(r_last_grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_own_data = req_data[int'(r_last_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign w_own_last = req_last[r_last_grant];
  assign w_hs       = (r_state == BURST) && req_valid[r_last_grant];

  assign w_exit = w_hs ? (w_own_last || (r_beat_cnt == BW'(MAX_BURST - 1)))
                       : (r_gap_cnt == GW'(GAP_MAX - 1));

`ifdef DSP_MEM_WRITE_ARB_ADDR_CHECK_EN
  logic w_rsvd;
  logic r_err;
  assign w_rsvd = !w_own_addr[CMD_SEL_BIT] && (w_own_addr[RSVD_MSB:RSVD_LSB] != 2'b00);
  assign w_fwd  = !w_rsvd;

  always_ff @(posedge clk) begin
    if (reset)              r_err <= 1'b0;
    else if (w_hs && w_rsvd) r_err <= 1'b1;
  end
  assign err_reserved = r_err;
`else
  assign w_fwd        = 1'b1;
  assign err_reserved = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= BURST;
            r_grant      <= N_REQ'(1) << w_sel;
            r_last_grant <= w_sel;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
          end
        end
        BURST: begin
          if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_gap_cnt  <= '0;
            if (w_fwd) begin
              r_wr_addr <= w_own_addr;
              r_wr_data <= w_own_data;
              r_wr_en   <= 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
          // Normal last beat and forced release take the same path back.
          if (w_exit) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == BURST) ? r_grant : '0;
  assign grant          = r_grant;
  assign busy           = (r_state == BURST);
  assign mem_write_addr = r_wr_addr;
  assign mem_write_data = r_wr_data;
  assign mem_write_en   = r_wr_en;

endmodule
